control_seq: RTL and testbench
==============================

Name: control_seq

Overview:
- Parametrised, sequenced successor to the Nandy combinational control decoder.
- Latches instructions through a valid/ready handshake and generates the cycle bit internally (1 cycle for non-memory ops, 2 for memory/jump ops).
- Stalls on memory not-ready and holds the carry flag in a register.
- Sits between the fetch stage and the datapath; drives all datapath control strobes.

Parameters:
- INST_W, 8, instruction width (>= 8); class nibble is inst[INST_W-1:INST_W-4], low nibble is inst[3:0]
- RS_W, 2, register-select field width, taken from inst[RS_W-1:0]
- ALU_W, 4, ALU opcode field width, taken from inst[ALU_W-1:0] (<= INST_W-4)
- SIG_N, 8, number of one-hot signal lines (power of 2, <= 8); index is inst[log2(SIG_N)-1:0]
- RET_W, 16, retire counter width (optional feature only)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- inst_valid  in  1  instruction offered
- inst  in  INST_W  instruction word
- inst_ready  out  1  block can accept an instruction
- alu_carry  in  1  carry out of ALU, captured when WC is high
- mem_ready  in  1  memory ready; low stalls memory cycle 0
- cycle  out  1  current execute cycle (0/1)
- busy  out  1  instruction in execution
- carry  out  1  registered carry flag
- M, S, J, LJ, CLI, LJR, MW, MC, RD, WR, Y, ISP, WA, WC  out  1 each  datapath strobes
- RS  out  RS_W  register select
- ALU  out  ALU_W  ALU opcode
- SIG  out  SIG_N  one-hot signal lines

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE; IR, carry and cycle clear to 0.
  - All strobes, RS, ALU and SIG are 0.
  - inst_ready is 1 once rst deasserts.
- States:
  - IDLE: inst_ready=1, busy=0, all strobes 0. Handshake is inst_valid & inst_ready at the edge; it loads IR and goes to EX0.
  - EX0: cycle=0, busy=1.
    - If t3=0: the instruction completes and the next state is IDLE.
    - If t3=1 and mem_ready=1: go to EX1.
    - If t3=1 and mem_ready=0: stay in EX0 with all outputs held.
  - EX1: cycle=1, busy=1; next state is IDLE.
  - No back-to-back acceptance: inst_ready is 0 in EX0/EX1, so the minimum issue interval is 2 clocks.
- Decode: combinational from IR and state; t3..t0 is the class nibble, b3..b0 is the low nibble.
  - M = t3 & ~t2 & cycle; MW = M & t1; MC = t3 & ~cycle & busy
  - S = t0; Y = t1; RS = IR[RS_W-1:0]; ALU = IR[ALU_W-1:0] (both only while busy, else 0)
  - J = t3 & t2 & t1 & cycle & ~(carry & t0)
  - LJ = ~t3 & ~t2 & ~t1 & t0 & ~b3; CLI = LJ & b1; LJR = LJ & b2
  - RD = ~t3 & ~t2 & ~t1 & ~t0 & b2; WR = same with b3
  - ISP = ~t3 & ~t2 & t1
  - WA = (M & ~t1) | (((t2 & ~t3) | (cycle & t2 & t1)) & ~(t0 & ~b3))
  - WC = (((t2 & ~t3) | (cycle & t2 & t1)) | ISP) & t0
  - SIG = (1 << index) when ~t3 & ~t2 & ~t1 & t0 & b3, else 0
  - All outputs are gated to 0 outside EX0/EX1.
- Carry:
  - At the clock edge where WC=1 and the state is not stalled, carry takes alu_carry.
  - J uses the registered carry value from before that edge.
  - A stalled EX0 never updates carry.
- Reset mid-instruction: immediate return to IDLE, with the carry flag and the instruction both discarded.

Optional Feature:
- Macro CONTROL_SEQ_RETIRE_EN.
- Defined:
  - Adds outputs retire (1-bit pulse) and retire_cnt (RET_W).
  - retire is high for the single cycle in which an instruction leaves EX0 (t3=0) or EX1.
  - retire_cnt increments on each retire, wraps modulo 2^RET_W, and resets to 0.
- Undefined: neither port exists; no counter logic.

Test Plan:
- Reset: assert rst mid-EX0 of 0x90 -> all outputs 0 asynchronously; after release, inst_ready=1, carry=0, busy=0.
- Single-cycle op: issue 0x50 with alu_carry=1 -> one EX0 cycle with WA=0, WC=1, S=1; carry=1 after the edge; back to IDLE.
- Memory op with stall: issue 0xA3, mem_ready=0 for 3 clocks -> MC=1 held 4 clocks, carry and outputs unchanged; then EX1 with M=1, MW=1, RS=3.
- Conditional jump: carry=1 then 0xF3 -> EX1 J=0; carry=0 then 0xF3 -> J=1; 0xE0 with carry=1 -> J=1.
- Signal decode: 0x1B -> SIG=0x08, LJ=0; 0x16 -> LJ=1, CLI=1, LJR=1, SIG=0.
- Retire counter (macro on, RET_W=2): retire 5 instructions -> retire_cnt=1 (wrap), one retire pulse each.

Source files
------------

// File: rtl/control_seq.sv
// control_seq: sequenced control decoder with valid/ready intake, memory stall and a registered carry flag.
// Define CONTROL_SEQ_RETIRE_EN to add the retire pulse and retire_cnt counter.
module control_seq #(
    parameter int INST_W = 8,
    parameter int RS_W   = 2,
    parameter int ALU_W  = 4,
    parameter int SIG_N  = 8,
    parameter int RET_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_valid,
    input  logic [INST_W-1:0] inst,
    output logic              inst_ready,
    input  logic              alu_carry,
    input  logic              mem_ready,
    output logic              cycle,
    output logic              busy,
    output logic              carry,
    output logic              M,
    output logic              S,
    output logic              J,
    output logic              LJ,
    output logic              CLI,
    output logic              LJR,
    output logic              MW,
    output logic              MC,
    output logic              RD,
    output logic              WR,
    output logic              Y,
    output logic              ISP,
    output logic              WA,
    output logic              WC,
    output logic [RS_W-1:0]   RS,
    output logic [ALU_W-1:0]  ALU,
    output logic [SIG_N-1:0]  SIG
`ifdef CONTROL_SEQ_RETIRE_EN
    ,
    output logic              retire,
    output logic [RET_W-1:0]  retire_cnt
`endif
);

    localparam int SIG_IW = (SIG_N > 1) ? $clog2(SIG_N) : 1;

    typedef enum logic [1:0] {IDLE, EX0, EX1} stateT;

    stateT             curState;
    stateT             nextState;
    logic [INST_W-1:0] ir;
    logic              carryQ;
    logic              t3, t2, t1, t0, b3, b2, b1;
    logic              take;
    logic              stall;
    logic              aluGrp;

    assign t3 = ir[INST_W-1];
    assign t2 = ir[INST_W-2];
    assign t1 = ir[INST_W-3];
    assign t0 = ir[INST_W-4];
    assign b3 = ir[3];
    assign b2 = ir[2];
    assign b1 = ir[1];

    assign take  = inst_valid & inst_ready;
    assign stall = (curState == EX0) & t3 & ~mem_ready;
    assign carry = carryQ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            curState <= IDLE;
        end else begin
            curState <= nextState;
        end
    end

    always_comb begin
        nextState = curState;
        unique case (curState)
            IDLE: if (take) nextState = EX0;
            EX0: begin
                if (!t3) begin
                    nextState = IDLE;
                end else if (mem_ready) begin
                    nextState = EX1;
                end
            end
            EX1:     nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        inst_ready = (curState == IDLE);
        busy       = (curState != IDLE);
        cycle      = (curState == EX1);
        aluGrp     = (t2 & ~t3) | (cycle & t2 & t1);
        M   = 1'b0;
        S   = 1'b0;
        J   = 1'b0;
        LJ  = 1'b0;
        CLI = 1'b0;
        LJR = 1'b0;
        MW  = 1'b0;
        MC  = 1'b0;
        RD  = 1'b0;
        WR  = 1'b0;
        Y   = 1'b0;
        ISP = 1'b0;
        WA  = 1'b0;
        WC  = 1'b0;
        RS  = '0;
        ALU = '0;
        SIG = '0;
        if (busy) begin
            M   = t3 & ~t2 & cycle;
            MW  = t3 & ~t2 & cycle & t1;
            MC  = t3 & ~cycle;
            S   = t0;
            Y   = t1;
            RS  = ir[RS_W-1:0];
            ALU = ir[ALU_W-1:0];
            // J reads the flag as it stood before this edge's possible capture
            J   = t3 & t2 & t1 & cycle & ~(carryQ & t0);
            LJ  = ~t3 & ~t2 & ~t1 & t0 & ~b3;
            CLI = ~t3 & ~t2 & ~t1 & t0 & ~b3 & b1;
            LJR = ~t3 & ~t2 & ~t1 & t0 & ~b3 & b2;
            RD  = ~t3 & ~t2 & ~t1 & ~t0 & b2;
            WR  = ~t3 & ~t2 & ~t1 & ~t0 & b3;
            ISP = ~t3 & ~t2 & t1;
            WA  = (t3 & ~t2 & cycle & ~t1) | (aluGrp & ~(t0 & ~b3));
            WC  = (aluGrp | (~t3 & ~t2 & t1)) & t0;
            if (~t3 & ~t2 & ~t1 & t0 & b3) begin
                SIG[ir[SIG_IW-1:0]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir     <= '0;
            carryQ <= 1'b0;
        end else begin
            if (take) begin
                ir <= inst;
            end
            if (WC && !stall) begin
                carryQ <= alu_carry;
            end
        end
    end

`ifdef CONTROL_SEQ_RETIRE_EN
    assign retire = ((curState == EX0) & ~t3) | (curState == EX1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_cnt <= '0;
        end else if (retire) begin
            retire_cnt <= retire_cnt + RET_W'(1);
        end
    end
`else
    if (RET_W < 1) begin : gRetWidthUnused
    end
`endif

endmodule

// File: tb/tb_control_seq.sv
// Randomised scoreboard bench for control_seq: the driver pushes expected per-cycle outputs, a negedge monitor checks them.
module tb_control_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       inst_valid;
    logic [7:0] inst;
    logic       inst_ready;
    logic       alu_carry;
    logic       mem_ready;
    logic       cycle, busy, carry;
    logic       M, S, J, LJ, CLI, LJR, MW, MC, RD, WR, Y, ISP, WA, WC;
    logic [1:0] RS;
    logic [3:0] ALU;
    logic [7:0] SIG;
`ifdef CONTROL_SEQ_RETIRE_EN
    logic       retire;
    logic [1:0] retire_cnt;
`endif

    always #5 clk = ~clk;

`ifdef CONTROL_SEQ_RETIRE_EN
    control_seq #(.RET_W(2)) dut (
`else
    control_seq dut (
`endif
        .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst(inst), .inst_ready(inst_ready),
        .alu_carry(alu_carry), .mem_ready(mem_ready), .cycle(cycle), .busy(busy), .carry(carry),
        .M(M), .S(S), .J(J), .LJ(LJ), .CLI(CLI), .LJR(LJR), .MW(MW), .MC(MC), .RD(RD), .WR(WR),
        .Y(Y), .ISP(ISP), .WA(WA), .WC(WC), .RS(RS), .ALU(ALU), .SIG(SIG)
`ifdef CONTROL_SEQ_RETIRE_EN
        , .retire(retire), .retire_cnt(retire_cnt)
`endif
    );

    typedef struct packed {
        logic [13:0] str;   // {M,S,J,LJ,CLI,LJR,MW,MC,RD,WR,Y,ISP,WA,WC}
        logic [1:0]  rs;
        logic [3:0]  alu;
        logic [7:0]  sig;
        logic        cyc;
        logic        cy;
        logic        last;
    } expT;

    expT  sbq[$];
    int   checks   = 0;
    int   failures = 0;
    bit   monEn    = 1'b0;
    logic mcarry   = 1'b0;
    int   retCnt   = 0;

    // Reference: per-cycle outputs from instruction class and low nibble
    function automatic expT model(input logic [7:0] ins, input logic cyc, input logic cy, input logic last);
        expT e;
        int  cls    = int'(ins[7:4]);
        int  lo     = int'(ins[3:0]);
        bit  isMem  = (cls >= 8) && (cls <= 11);
        bit  isJmp  = (cls >= 14);
        bit  odd    = (cls % 2) == 1;
        bit  aluGrp = ((cls >= 4) && (cls <= 7)) || (isJmp && cyc);
        bit  m, mw, mc, j, lj, cli, ljr, rd, wr, y, isp, wa, wc;
        m   = isMem && cyc;
        mw  = m && (cls >= 10);
        mc  = (cls >= 8) && !cyc;
        j   = isJmp && cyc && !((cls == 15) && cy);
        lj  = (cls == 1) && (lo < 8);
        cli = lj && ((lo / 2) % 2 == 1);
        ljr = lj && ((lo / 4) % 2 == 1);
        rd  = (cls == 0) && ((lo / 4) % 2 == 1);
        wr  = (cls == 0) && (lo >= 8);
        y   = ((cls / 2) % 2) == 1;
        isp = (cls == 2) || (cls == 3);
        wa  = (m && (cls <= 9)) || (aluGrp && !(odd && (lo < 8)));
        wc  = (aluGrp || isp) && odd;
        e.str  = {m, odd, j, lj, cli, ljr, mw, mc, rd, wr, y, isp, wa, wc};
        e.rs   = 2'(lo % 4);
        e.alu  = 4'(lo);
        e.sig  = ((cls == 1) && (lo >= 8)) ? 8'(1 << (lo % 8)) : 8'h00;
        e.cyc  = cyc;
        e.cy   = cy;
        e.last = last;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (monEn) begin
            expT a;
            expT e;
            chk("ready_vs_busy", 32'(inst_ready), 32'(!busy));
            a.str  = {M, S, J, LJ, CLI, LJR, MW, MC, RD, WR, Y, ISP, WA, WC};
            a.rs   = RS;
            a.alu  = ALU;
            a.sig  = SIG;
            a.cyc  = cycle;
            a.cy   = carry;
`ifdef CONTROL_SEQ_RETIRE_EN
            a.last = retire;
`else
            a.last = 1'b0;
`endif
            if (busy) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_busy", 32'(busy), 32'h0);
                end else begin
                    e = sbq.pop_front();
`ifndef CONTROL_SEQ_RETIRE_EN
                    e.last = 1'b0;
`endif
                    checks++;
                    if (a !== e) begin
                        failures++;
                        $display("FAIL exec_cycle: got %h expected %h at %0t", a, e, $time);
                    end
                end
            end else begin
                chk("idle_outputs", {a.str, a.rs, a.alu, a.sig, a.cyc, a.last}, 32'h0);
            end
        end
    end

    task automatic issue(input logic [7:0] ins, input logic ac, input int stallsIn);
        int  stalls = ins[7] ? stallsIn : 0;
        expT e;
        bit  ok = 1'b0;
        for (int i = 0; i <= stalls; i++) begin
            e = model(ins, 1'b0, mcarry, !ins[7]);
            sbq.push_back(e);
            if (e.str[0] && (i == stalls)) mcarry = ac;
        end
        if (ins[7]) begin
            e = model(ins, 1'b1, mcarry, 1'b1);
            sbq.push_back(e);
            if (e.str[0]) mcarry = ac;
        end
        retCnt++;
        inst       = ins;
        inst_valid = 1'b1;
        alu_carry  = ac;
        mem_ready  = (stalls == 0);
        @(posedge clk);
        #1;
        inst_valid = 1'b0;
        inst       = 8'($urandom);
        repeat (stalls) begin
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (inst_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("ready_timeout", 32'(inst_ready), 32'h1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        inst_valid = 1'b0;
        inst       = 8'h00;
        alu_carry  = 1'b0;
        mem_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {M, S, J, LJ, CLI, LJR, MW, MC, RD, WR, Y, ISP, WA, WC, RS, ALU, SIG}, 32'h0);
        rst = 1'b0;
        #1;
        chk("reset_ready", {inst_ready, busy, carry}, 32'b100);
        monEn = 1'b1;

        // Set carry, then reset during a stalled 0x90
        issue(8'h50, 1'b1, 0);
        chk("carry_set", 32'(carry), 32'h1);
        monEn      = 1'b0;
        inst       = 8'h90;
        inst_valid = 1'b1;
        mem_ready  = 1'b0;
        @(posedge clk);
        #1;
        inst_valid = 1'b0;
        chk("ex0_0x90", {busy, MC, M}, 32'b110);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset", {busy, cycle, carry, M, S, J, LJ, CLI, LJR, MW, MC, RD, WR, Y, ISP, WA, WC, RS, ALU, SIG}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("after_reset", {inst_ready, busy, carry}, 32'b100);
        mcarry    = 1'b0;
        retCnt    = 0;
        mem_ready = 1'b1;
        sbq.delete();
        monEn = 1'b1;

        // Directed scenarios
        issue(8'h50, 1'b1, 0);
        issue(8'hA3, 1'b0, 3);
        issue(8'h50, 1'b1, 0);
        issue(8'hF3, 1'b0, 0);
        issue(8'hF3, 1'b1, 0);
        issue(8'hE0, 1'b0, 0);
        issue(8'h1B, 1'b0, 0);
        issue(8'h16, 1'b0, 0);

        for (int n = 0; n < 300; n++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            issue(8'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        @(posedge clk);
        #1;
        chk("queue_drained", 32'(sbq.size()), 32'h0);
        chk("final_carry", 32'(carry), 32'(mcarry));
`ifdef CONTROL_SEQ_RETIRE_EN
        chk("retire_cnt", 32'(retire_cnt), 32'(retCnt % 4));
`endif
        monEn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
